// File: rtl/snitch_icache_pkg.sv
// Shared types for the Snitch instruction cache.
// Holds the cache configuration and the refill pending-table entry.
package snitch_icache_pkg;

  typedef struct packed {
    int unsigned FETCH_AW;
    int unsigned ID_WIDTH;
    int unsigned LINE_WIDTH;
    int unsigned LINE_ALIGN;
    int unsigned COUNT_ALIGN;
    int unsigned SET_ALIGN;
    int unsigned WAY_COUNT;
    int unsigned TAG_WIDTH;
    int unsigned PENDING_COUNT;
    int unsigned PENDING_IW;
  } config_t;

  localparam config_t DEFAULT_CFG = '{
    FETCH_AW:      32,
    ID_WIDTH:      4,
    LINE_WIDTH:    128,
    LINE_ALIGN:    4,
    COUNT_ALIGN:   5,
    SET_ALIGN:     2,
    WAY_COUNT:     4,
    TAG_WIDTH:     23,
    PENDING_COUNT: 2,
    PENDING_IW:    1
  };

  localparam int unsigned PT_LINE_W =
    DEFAULT_CFG.FETCH_AW - DEFAULT_CFG.LINE_ALIGN;
  localparam int unsigned PT_ID_W = DEFAULT_CFG.ID_WIDTH;

  typedef struct packed {
    logic                 valid;
    logic [PT_LINE_W-1:0] line;
    logic [PT_ID_W-1:0]   idmask;
  } pending_entry_t;

endpackage

// File: rtl/snitch_icache_pending_table.sv
// Outstanding-miss table: line CAM, lowest-free allocation,
// same-line coalescing and free-by-index on refill retire.
module snitch_icache_pending_table
  import snitch_icache_pkg::*;
#(
  parameter config_t CFG = DEFAULT_CFG
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [CFG.FETCH_AW-CFG.LINE_ALIGN-1:0] i_lookup_line,
  output logic                                  o_match,
  output logic [CFG.PENDING_IW-1:0]             o_match_idx,
  output logic                                  o_free,
  output logic [CFG.PENDING_IW-1:0]             o_free_idx,
  input  logic                                  i_coalesce,
  input  logic [CFG.ID_WIDTH-1:0]               i_coalesce_id,
  input  logic                                  i_alloc,
  input  logic [CFG.ID_WIDTH-1:0]               i_alloc_id,
  input  logic                                  i_retire,
  input  logic [CFG.PENDING_IW-1:0]             i_retire_idx,
  output logic                                  o_retire_valid,
  output logic [CFG.FETCH_AW-CFG.LINE_ALIGN-1:0] o_retire_line,
  output logic [CFG.ID_WIDTH-1:0]               o_retire_idmask
);

  localparam int unsigned PC  = CFG.PENDING_COUNT;
  localparam int unsigned PIW = CFG.PENDING_IW;

  pending_entry_t r_tab [PC];

  logic           w_match;
  logic [PIW-1:0] w_match_idx;
  logic           w_free;
  logic [PIW-1:0] w_free_idx;

  // CAM lookup and lowest-free search; descending loop lets index 0 win
  always_comb begin
    w_match     = 1'b0;
    w_match_idx = '0;
    w_free      = 1'b0;
    w_free_idx  = '0;
    for (int i = PC - 1; i >= 0; i--) begin
      if (r_tab[i].valid && r_tab[i].line == i_lookup_line) begin
        w_match     = 1'b1;
        w_match_idx = PIW'(i);
      end
      if (!r_tab[i].valid) begin
        w_free     = 1'b1;
        w_free_idx = PIW'(i);
      end
    end
  end

  assign o_match     = w_match;
  assign o_match_idx = w_match_idx;
  assign o_free      = w_free;
  assign o_free_idx  = w_free_idx;

  assign o_retire_valid  = r_tab[i_retire_idx].valid;
  assign o_retire_line   = r_tab[i_retire_idx].line;
  assign o_retire_idmask = r_tab[i_retire_idx].idmask;

  // Entry update; retire beats coalesce so a late joiner rides the retiring response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < PC; i++) r_tab[i] <= '0;
    end else begin
      for (int i = 0; i < PC; i++) begin
        if (i_alloc && w_free_idx == PIW'(i)) begin
          r_tab[i].valid  <= 1'b1;
          r_tab[i].line   <= i_lookup_line;
          r_tab[i].idmask <= i_alloc_id;
        end else if (i_retire && i_retire_idx == PIW'(i)) begin
          r_tab[i].valid <= 1'b0;
        end else if (i_coalesce && w_match_idx == PIW'(i)) begin
          r_tab[i].idmask <= r_tab[i].idmask | i_coalesce_id;
        end
      end
    end
  end

endmodule

// File: rtl/snitch_icache_refill_handler.sv
// L1 lookup consumer: forwards hits, tracks and coalesces misses,
// refills lines from L2, writes them into L1 and answers requesters.
module snitch_icache_refill_handler
  import snitch_icache_pkg::*;
#(
  parameter config_t CFG = DEFAULT_CFG
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [CFG.FETCH_AW-1:0]     in_req_addr_i,
  input  logic [CFG.ID_WIDTH-1:0]     in_req_id_i,
  input  logic                        in_req_hit_i,
  input  logic [CFG.LINE_WIDTH-1:0]   in_req_data_i,
  input  logic                        in_req_error_i,
  input  logic                        in_req_valid_i,
  output logic                        in_req_ready_o,
  output logic [CFG.LINE_WIDTH-1:0]   in_rsp_data_o,
  output logic                        in_rsp_error_o,
  output logic [CFG.ID_WIDTH-1:0]     in_rsp_id_o,
  output logic                        in_rsp_valid_o,
  input  logic                        in_rsp_ready_i,
  output logic [CFG.COUNT_ALIGN-1:0]  write_addr_o,
  output logic [CFG.SET_ALIGN-1:0]    write_set_o,
  output logic [CFG.LINE_WIDTH-1:0]   write_data_o,
  output logic [CFG.TAG_WIDTH-1:0]    write_tag_o,
  output logic                        write_error_o,
  output logic                        write_valid_o,
  input  logic                        write_ready_i,
  output logic [CFG.FETCH_AW-1:0]     out_req_addr_o,
  output logic [CFG.PENDING_IW-1:0]   out_req_id_o,
  output logic                        out_req_valid_o,
  input  logic                        out_req_ready_i,
  input  logic [CFG.LINE_WIDTH-1:0]   out_rsp_data_i,
  input  logic                        out_rsp_error_i,
  input  logic [CFG.PENDING_IW-1:0]   out_rsp_id_i,
  input  logic                        out_rsp_valid_i,
  output logic                        out_rsp_ready_o
);

  localparam int unsigned AW  = CFG.FETCH_AW;
  localparam int unsigned LA  = CFG.LINE_ALIGN;
  localparam int unsigned LW  = AW - LA;
  localparam int unsigned CA  = CFG.COUNT_ALIGN;
  localparam int unsigned SW  = CFG.SET_ALIGN;
  localparam int unsigned IDW = CFG.ID_WIDTH;
  localparam int unsigned PIW = CFG.PENDING_IW;
  localparam int unsigned DW  = CFG.LINE_WIDTH;

  logic [LW-1:0]  w_line;
  logic           w_match;
  logic [PIW-1:0] w_match_idx;
  logic           w_free;
  logic [PIW-1:0] w_free_idx;
  logic           w_ret_valid;
  logic [LW-1:0]  w_ret_line;
  logic [IDW-1:0] w_ret_idmask;
  logic           w_slot_free;
  logic           w_refill_fire;
  logic           w_wr_valid;
  logic           w_oreq_free;
  logic           w_miss;
  logic           w_hit_fire;
  logic           w_coalesce;
  logic           w_alloc;
  logic [IDW-1:0] w_rsp_id;

  logic           r_rsp_valid;
  logic [DW-1:0]  r_rsp_data;
  logic           r_rsp_error;
  logic [IDW-1:0] r_rsp_id;
  logic           r_oreq_valid;
  logic [AW-1:0]  r_oreq_addr;
  logic [PIW-1:0] r_oreq_id;
  logic [SW-1:0]  r_victim;

  assign w_line = in_req_addr_i[AW-1:LA];

  snitch_icache_pending_table #(
    .CFG (CFG)
  ) i_table (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .i_lookup_line   (w_line),
    .o_match         (w_match),
    .o_match_idx     (w_match_idx),
    .o_free          (w_free),
    .o_free_idx      (w_free_idx),
    .i_coalesce      (w_coalesce),
    .i_coalesce_id   (in_req_id_i),
    .i_alloc         (w_alloc),
    .i_alloc_id      (in_req_id_i),
    .i_retire        (w_refill_fire),
    .i_retire_idx    (out_rsp_id_i),
    .o_retire_valid  (w_ret_valid),
    .o_retire_line   (w_ret_line),
    .o_retire_idmask (w_ret_idmask)
  );

  // Handshake decisions; a retiring refill owns the response slot
  always_comb begin
    w_slot_free   = !r_rsp_valid | in_rsp_ready_i;
    w_refill_fire = out_rsp_valid_i & write_ready_i & w_slot_free;
    w_wr_valid    = out_rsp_valid_i & w_slot_free;
    w_oreq_free   = !r_oreq_valid | out_req_ready_i;
    w_miss        = in_req_valid_i & !in_req_hit_i;
    w_hit_fire    = in_req_valid_i & in_req_hit_i
                  & w_slot_free & !w_refill_fire;
    w_coalesce    = w_miss & w_match;
    w_alloc       = w_miss & !w_match & w_free & w_oreq_free;
    w_rsp_id      = w_ret_idmask;
    if (w_coalesce && w_match_idx == out_rsp_id_i)
      w_rsp_id = w_ret_idmask | in_req_id_i;
  end

  assign in_req_ready_o  = w_hit_fire | w_coalesce | w_alloc;
  assign out_rsp_ready_o = w_refill_fire;
  assign write_valid_o   = w_wr_valid;
  assign write_addr_o    = w_wr_valid ? w_ret_line[CA-1:0] : '0;
  assign write_tag_o     = w_wr_valid ? w_ret_line[LW-1:CA] : '0;
  assign write_set_o     = w_wr_valid ? r_victim : '0;
  assign write_data_o    = w_wr_valid ? out_rsp_data_i : '0;
  assign write_error_o   = w_wr_valid & out_rsp_error_i;

  assign in_rsp_valid_o  = r_rsp_valid;
  assign in_rsp_data_o   = r_rsp_data;
  assign in_rsp_error_o  = r_rsp_error;
  assign in_rsp_id_o     = r_rsp_id;
  assign out_req_valid_o = r_oreq_valid;
  assign out_req_addr_o  = r_oreq_addr;
  assign out_req_id_o    = r_oreq_id;

  // Response register: refill data first, otherwise a hit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
      r_rsp_id    <= '0;
    end else if (w_refill_fire) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= out_rsp_data_i;
      r_rsp_error <= out_rsp_error_i;
      r_rsp_id    <= w_rsp_id;
    end else if (w_hit_fire) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= in_req_data_i;
      r_rsp_error <= in_req_error_i;
      r_rsp_id    <= in_req_id_i;
    end else if (in_rsp_ready_i) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // Refill request register: held stable until L2 accepts it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_oreq_valid <= 1'b0;
      r_oreq_addr  <= '0;
      r_oreq_id    <= '0;
    end else if (w_alloc) begin
      r_oreq_valid <= 1'b1;
      r_oreq_addr  <= {w_line, {LA{1'b0}}};
      r_oreq_id    <= w_free_idx;
    end else if (out_req_ready_i) begin
      r_oreq_valid <= 1'b0;
    end
  end

  // Round-robin victim way, advanced once per retired refill
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_victim <= '0;
    end else if (w_refill_fire) begin
      if (r_victim == SW'(CFG.WAY_COUNT - 1)) r_victim <= '0;
      else r_victim <= r_victim + 1'b1;
    end
  end

  a_rsp_id_valid : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    out_rsp_valid_i |-> w_ret_valid
  );

endmodule

// File: tb/tb_snitch_icache_refill_handler.sv
// Scoreboard bench for the icache refill handler.
// Expected transfers are queued by stimulus and popped by a monitor.
module tb_snitch_icache_refill_handler;
  import snitch_icache_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [31:0]  in_req_addr_i;
  logic [3:0]   in_req_id_i;
  logic         in_req_hit_i;
  logic [127:0] in_req_data_i;
  logic         in_req_error_i;
  logic         in_req_valid_i;
  logic         in_req_ready_o;
  logic [127:0] in_rsp_data_o;
  logic         in_rsp_error_o;
  logic [3:0]   in_rsp_id_o;
  logic         in_rsp_valid_o;
  logic         in_rsp_ready_i;
  logic [4:0]   write_addr_o;
  logic [1:0]   write_set_o;
  logic [127:0] write_data_o;
  logic [22:0]  write_tag_o;
  logic         write_error_o;
  logic         write_valid_o;
  logic         write_ready_i;
  logic [31:0]  out_req_addr_o;
  logic [0:0]   out_req_id_o;
  logic         out_req_valid_o;
  logic         out_req_ready_i;
  logic [127:0] out_rsp_data_i;
  logic         out_rsp_error_i;
  logic [0:0]   out_rsp_id_i;
  logic         out_rsp_valid_i;
  logic         out_rsp_ready_o;

  snitch_icache_refill_handler #(.CFG(DEFAULT_CFG)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .in_req_addr_i   (in_req_addr_i),
    .in_req_id_i     (in_req_id_i),
    .in_req_hit_i    (in_req_hit_i),
    .in_req_data_i   (in_req_data_i),
    .in_req_error_i  (in_req_error_i),
    .in_req_valid_i  (in_req_valid_i),
    .in_req_ready_o  (in_req_ready_o),
    .in_rsp_data_o   (in_rsp_data_o),
    .in_rsp_error_o  (in_rsp_error_o),
    .in_rsp_id_o     (in_rsp_id_o),
    .in_rsp_valid_o  (in_rsp_valid_o),
    .in_rsp_ready_i  (in_rsp_ready_i),
    .write_addr_o    (write_addr_o),
    .write_set_o     (write_set_o),
    .write_data_o    (write_data_o),
    .write_tag_o     (write_tag_o),
    .write_error_o   (write_error_o),
    .write_valid_o   (write_valid_o),
    .write_ready_i   (write_ready_i),
    .out_req_addr_o  (out_req_addr_o),
    .out_req_id_o    (out_req_id_o),
    .out_req_valid_o (out_req_valid_o),
    .out_req_ready_i (out_req_ready_i),
    .out_rsp_data_i  (out_rsp_data_i),
    .out_rsp_error_i (out_rsp_error_i),
    .out_rsp_id_i    (out_rsp_id_i),
    .out_rsp_valid_i (out_rsp_valid_i),
    .out_rsp_ready_o (out_rsp_ready_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0]   id;
    logic [127:0] data;
    logic         err;
  } rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [0:0]  id;
  } oreq_t;

  typedef struct packed {
    logic [4:0]   addr;
    logic [1:0]   set;
    logic [22:0]  tag;
    logic [127:0] data;
    logic         err;
  } wr_t;

  rsp_t  exp_rsp  [$];
  oreq_t exp_oreq [$];
  wr_t   exp_wr   [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic monitor();
    rsp_t  er, ar;
    oreq_t eo, ao;
    wr_t   ew, aw;
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (in_rsp_valid_o && in_rsp_ready_i) begin
          n_checks++;
          ar = '{in_rsp_id_o, in_rsp_data_o, in_rsp_error_o};
          if (exp_rsp.size() == 0) begin
            n_fail++;
            $display("FAIL rsp unexpected: got %h", ar);
          end else begin
            er = exp_rsp.pop_front();
            if (ar !== er) begin
              n_fail++;
              $display("FAIL rsp: got %h want %h", ar, er);
            end
          end
        end
        if (out_req_valid_o && out_req_ready_i) begin
          n_checks++;
          ao = '{out_req_addr_o, out_req_id_o};
          if (exp_oreq.size() == 0) begin
            n_fail++;
            $display("FAIL oreq unexpected: got %h", ao);
          end else begin
            eo = exp_oreq.pop_front();
            if (ao !== eo) begin
              n_fail++;
              $display("FAIL oreq: got %h want %h", ao, eo);
            end
          end
        end
        if (write_valid_o && write_ready_i) begin
          n_checks++;
          aw = '{write_addr_o, write_set_o, write_tag_o,
                 write_data_o, write_error_o};
          if (exp_wr.size() == 0) begin
            n_fail++;
            $display("FAIL write unexpected: got %h", aw);
          end else begin
            ew = exp_wr.pop_front();
            if (aw !== ew) begin
              n_fail++;
              $display("FAIL write: got %h want %h", aw, ew);
            end
          end
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [7:0] got,
                       input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic send_req(input logic [31:0] addr, input logic [3:0] id,
                          input logic hit, input logic [127:0] data);
    logic rdy;
    int   n;
    in_req_addr_i  = addr;
    in_req_id_i    = id;
    in_req_hit_i   = hit;
    in_req_data_i  = data;
    in_req_error_i = 1'b0;
    in_req_valid_i = 1'b1;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 100) begin
      @(negedge clk_i);
      rdy = in_req_ready_o;
      @(posedge clk_i);
      #1;
      n++;
    end
    in_req_valid_i = 1'b0;
    if (!rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL req timeout: addr %h", addr);
    end
  endtask

  task automatic refill(input logic [0:0] idx, input logic [127:0] data,
                        input logic err);
    logic rdy;
    int   n;
    out_rsp_id_i    = idx;
    out_rsp_data_i  = data;
    out_rsp_error_i = err;
    out_rsp_valid_i = 1'b1;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 100) begin
      @(negedge clk_i);
      rdy = out_rsp_ready_o;
      @(posedge clk_i);
      #1;
      n++;
    end
    out_rsp_valid_i = 1'b0;
    if (!rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL refill timeout: idx %0d", idx);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    int n;
    rst_ni          = 1'b0;
    in_req_addr_i   = '0;
    in_req_id_i     = '0;
    in_req_hit_i    = 1'b0;
    in_req_data_i   = '0;
    in_req_error_i  = 1'b0;
    in_req_valid_i  = 1'b0;
    in_rsp_ready_i  = 1'b1;
    write_ready_i   = 1'b1;
    out_req_ready_i = 1'b1;
    out_rsp_data_i  = '0;
    out_rsp_error_i = 1'b0;
    out_rsp_id_i    = '0;
    out_rsp_valid_i = 1'b0;
    fork monitor(); join_none

    @(negedge clk_i);
    check("rst in_req_ready", {7'd0, in_req_ready_o}, 8'd0);
    check("rst in_rsp_valid", {7'd0, in_rsp_valid_o}, 8'd0);
    check("rst out_req_valid", {7'd0, out_req_valid_o}, 8'd0);
    check("rst write_valid", {7'd0, write_valid_o}, 8'd0);
    check("rst write_set", {6'd0, write_set_o}, 8'd0);
    idle(2);
    rst_ni = 1'b1;
    idle(1);

    // hit
    exp_rsp.push_back('{4'b0001, {16{8'hA5}}, 1'b0});
    send_req(32'h1000, 4'b0001, 1'b1, {16{8'hA5}});
    idle(3);

    // single miss and refill
    exp_oreq.push_back('{32'h2040, 1'b0});
    send_req(32'h2040, 4'b0001, 1'b0, '0);
    idle(3);
    exp_wr.push_back('{5'd4, 2'd0, 23'h10, {16{8'hD1}}, 1'b0});
    exp_rsp.push_back('{4'b0001, {16{8'hD1}}, 1'b0});
    refill(1'b0, {16{8'hD1}}, 1'b0);
    idle(2);

    // coalesced misses
    exp_oreq.push_back('{32'h2040, 1'b0});
    send_req(32'h2044, 4'b0001, 1'b0, '0);
    send_req(32'h2048, 4'b0010, 1'b0, '0);
    idle(3);
    exp_wr.push_back('{5'd4, 2'd1, 23'h10, {16{8'hD2}}, 1'b0});
    exp_rsp.push_back('{4'b0011, {16{8'hD2}}, 1'b0});
    refill(1'b0, {16{8'hD2}}, 1'b0);
    idle(2);

    // table full stall
    exp_oreq.push_back('{32'h3000, 1'b0});
    exp_oreq.push_back('{32'h4000, 1'b1});
    send_req(32'h3000, 4'b0001, 1'b0, '0);
    send_req(32'h4000, 4'b0010, 1'b0, '0);
    in_req_addr_i  = 32'h5000;
    in_req_id_i    = 4'b0100;
    in_req_hit_i   = 1'b0;
    in_req_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      check("full stall ready", {7'd0, in_req_ready_o}, 8'd0);
    end
    @(posedge clk_i);
    #1;
    exp_wr.push_back('{5'd0, 2'd2, 23'h18, {16{8'hDA}}, 1'b0});
    exp_rsp.push_back('{4'b0001, {16{8'hDA}}, 1'b0});
    exp_oreq.push_back('{32'h5000, 1'b0});
    fork
      send_req(32'h5000, 4'b0100, 1'b0, '0);
      refill(1'b0, {16{8'hDA}}, 1'b0);
    join
    idle(3);
    exp_wr.push_back('{5'd0, 2'd3, 23'h20, {16{8'hDB}}, 1'b0});
    exp_rsp.push_back('{4'b0010, {16{8'hDB}}, 1'b0});
    refill(1'b1, {16{8'hDB}}, 1'b0);
    exp_wr.push_back('{5'd0, 2'd0, 23'h28, {16{8'hDC}}, 1'b0});
    exp_rsp.push_back('{4'b0100, {16{8'hDC}}, 1'b0});
    refill(1'b0, {16{8'hDC}}, 1'b0);
    idle(2);

    // refill beats a hit in the same cycle
    exp_oreq.push_back('{32'h6000, 1'b0});
    send_req(32'h6000, 4'b0001, 1'b0, '0);
    idle(3);
    exp_wr.push_back('{5'd0, 2'd1, 23'h30, {16{8'hDE}}, 1'b0});
    exp_rsp.push_back('{4'b0001, {16{8'hDE}}, 1'b0});
    exp_rsp.push_back('{4'b0010, {16{8'h77}}, 1'b0});
    fork
      refill(1'b0, {16{8'hDE}}, 1'b0);
      send_req(32'h7000, 4'b0010, 1'b1, {16{8'h77}});
      begin
        @(negedge clk_i);
        check("prio hit ready", {7'd0, in_req_ready_o}, 8'd0);
        check("prio refill ready", {7'd0, out_rsp_ready_o}, 8'd1);
      end
    join
    idle(3);

    // refill error
    exp_oreq.push_back('{32'h9000, 1'b0});
    send_req(32'h9000, 4'b0001, 1'b0, '0);
    idle(3);
    exp_wr.push_back('{5'd0, 2'd2, 23'h48, {16{8'hDF}}, 1'b1});
    exp_rsp.push_back('{4'b0001, {16{8'hDF}}, 1'b1});
    refill(1'b0, {16{8'hDF}}, 1'b1);
    idle(2);

    // miss coalescing into an entry retiring the same cycle
    exp_oreq.push_back('{32'h8000, 1'b0});
    send_req(32'h8000, 4'b0001, 1'b0, '0);
    idle(3);
    exp_wr.push_back('{5'd0, 2'd3, 23'h40, {16{8'hD7}}, 1'b0});
    exp_rsp.push_back('{4'b1001, {16{8'hD7}}, 1'b0});
    fork
      refill(1'b0, {16{8'hD7}}, 1'b0);
      send_req(32'h8004, 4'b1000, 1'b0, '0);
    join

    n = 0;
    while ((exp_rsp.size() + exp_oreq.size() + exp_wr.size()) != 0
           && n < 50) begin
      idle(1);
      n++;
    end
    idle(3);
    check("rsp queue drained", 8'(exp_rsp.size()), 8'd0);
    check("oreq queue drained", 8'(exp_oreq.size()), 8'd0);
    check("write queue drained", 8'(exp_wr.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
